// File: rtl/cordic_sequencer.sv
// Sequencing controller for the iterative CORDIC datapath: decodes start/ack from the
// bus-side control register, steps the datapath through load/iterate/capture and writes status back.
module cordic_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ITER   = 16,
  parameter int ITER_W     = 5
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [DATA_WIDTH-1:0] ctrl_reg_in,
  output logic [DATA_WIDTH-1:0] ctrl_reg_out,
  output logic                  ctrl_reg_we,
  output logic                  dp_load,
  output logic                  dp_iter_en,
  output logic [ITER_W-1:0]     dp_iter_idx,
  output logic                  dp_mode,
  input  logic                  dp_overflow,
  output logic                  result_latch,
  output logic                  irq
);

  // state   | meaning
  // IDLE    | waiting for start or ack in the control register
  // LOAD    | dp_load pulse, busy write-back issued
  // ITER    | one micro-rotation per cycle, overflow accumulated
  // CAPTURE | result_latch pulse
  // DONE    | done / err_ovf write-back issued
  // ERR     | err_cfg write-back issued for an illegal count

  localparam int B_START   = 0;
  localparam int B_MODE    = 1;
  localparam int B_IE      = 2;
  localparam int B_ACK     = 3;
  localparam int B_ERR_CFG = 28;
  localparam int B_ERR_OVF = 29;
  localparam int B_BUSY    = 30;
  localparam int B_DONE    = 31;
  localparam int CNT_LSB   = 4;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] ctrl_out_q;
  logic                  we_q;
  logic                  stale_q;
  logic                  load_q;
  logic                  iter_en_q;
  logic                  rl_q;
  logic                  mode_q;
  logic                  ovf_q;
  logic                  irq_q;
  logic [ITER_W-1:0]     idx_q;
  logic [ITER_W-1:0]     iter_left_q;

  logic [CNT_W-1:0]      cnt_field;
  logic                  start_cmd;
  logic                  ack_cmd;
  logic                  cnt_ok;
  logic                  idle_armed;
  logic [DATA_WIDTH-1:0] wb_load_d;
  logic [DATA_WIDTH-1:0] wb_err_d;
  logic [DATA_WIDTH-1:0] wb_ack_d;
  logic [DATA_WIDTH-1:0] wb_done_d;

  always_comb begin
    cnt_field  = ctrl_reg_in[CNT_LSB +: CNT_W];
    start_cmd  = ctrl_reg_in[B_START];
    ack_cmd    = ctrl_reg_in[B_ACK];
    cnt_ok     = (cnt_field != '0) && (int'(cnt_field) <= MAX_ITER);
    // The bus copy lags a write-back, so the old start/ack bits must not re-trigger.
    idle_armed = !we_q && !stale_q;

    wb_load_d            = ctrl_reg_in;
    wb_load_d[B_START]   = 1'b0;
    wb_load_d[B_ACK]     = 1'b0;
    wb_load_d[B_BUSY]    = 1'b1;
    wb_load_d[B_DONE]    = 1'b0;
    wb_load_d[B_ERR_CFG] = 1'b0;
    wb_load_d[B_ERR_OVF] = 1'b0;

    wb_err_d             = ctrl_reg_in;
    wb_err_d[B_START]    = 1'b0;
    wb_err_d[B_ACK]      = 1'b0;
    wb_err_d[B_DONE]     = 1'b1;
    wb_err_d[B_ERR_CFG]  = 1'b1;
    wb_err_d[B_BUSY]     = 1'b0;

    wb_ack_d             = ctrl_reg_in;
    wb_ack_d[B_ACK]      = 1'b0;
    wb_ack_d[B_DONE]     = 1'b0;
    wb_ack_d[B_ERR_CFG]  = 1'b0;
    wb_ack_d[B_ERR_OVF]  = 1'b0;

    wb_done_d            = ctrl_reg_in;
    wb_done_d[B_START]   = 1'b0;
    wb_done_d[B_BUSY]    = 1'b0;
    wb_done_d[B_DONE]    = 1'b1;
    wb_done_d[B_ERR_OVF] = ovf_q;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      ctrl_out_q  <= '0;
      we_q        <= 1'b0;
      stale_q     <= 1'b0;
      load_q      <= 1'b0;
      iter_en_q   <= 1'b0;
      rl_q        <= 1'b0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      idx_q       <= '0;
      iter_left_q <= '0;
    end else begin
      load_q    <= 1'b0;
      we_q      <= 1'b0;
      rl_q      <= 1'b0;
      iter_en_q <= 1'b0;
      stale_q   <= we_q;
      irq_q     <= ctrl_reg_in[B_DONE] & ctrl_reg_in[B_IE];

      case (state_q)
        S_IDLE: begin
          if (idle_armed) begin
            if (start_cmd && cnt_ok) begin
              state_q     <= S_LOAD;
              iter_left_q <= ITER_W'(cnt_field);
              mode_q      <= ctrl_reg_in[B_MODE];
              ovf_q       <= 1'b0;
              load_q      <= 1'b1;
              we_q        <= 1'b1;
              ctrl_out_q  <= wb_load_d;
            end else if (start_cmd) begin
              state_q    <= S_ERR;
              we_q       <= 1'b1;
              ctrl_out_q <= wb_err_d;
            end else if (ack_cmd) begin
              we_q       <= 1'b1;
              ctrl_out_q <= wb_ack_d;
            end
          end
        end
        S_LOAD: begin
          state_q   <= S_ITER;
          iter_en_q <= 1'b1;
          idx_q     <= '0;
        end
        S_ITER: begin
          ovf_q <= ovf_q | dp_overflow;
          // iter_left_q counts remaining rotations including the current one.
          if (iter_left_q == ITER_W'(1)) begin
            state_q     <= S_CAPTURE;
            rl_q        <= 1'b1;
            idx_q       <= '0;
            iter_left_q <= '0;
          end else begin
            iter_en_q   <= 1'b1;
            idx_q       <= idx_q + ITER_W'(1);
            iter_left_q <= iter_left_q - ITER_W'(1);
          end
        end
        S_CAPTURE: begin
          state_q    <= S_DONE;
          we_q       <= 1'b1;
          ctrl_out_q <= wb_done_d;
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_reg_out = ctrl_out_q;
  assign ctrl_reg_we  = we_q;
  assign dp_load      = load_q;
  assign dp_iter_en   = iter_en_q;
  assign dp_iter_idx  = idx_q;
  assign dp_mode      = mode_q;
  assign result_latch = rl_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: models the bus-side control register and
// predicts each run's pulse/write-back timeline from the register field rules.
module tb_cordic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl_reg_in;
  logic [31:0] ctrl_reg_out;
  logic        ctrl_reg_we;
  logic        dp_load;
  logic        dp_iter_en;
  logic [4:0]  dp_iter_idx;
  logic        dp_mode;
  logic        dp_overflow;
  logic        result_latch;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;

  // bus-manager model state
  logic        pend_we;
  logic [31:0] pend_val;
  logic        sw_pend;
  logic [31:0] sw_val;

  always #5 clk = ~clk;

  cordic_sequencer #(.DATA_WIDTH(32), .MAX_ITER(16), .ITER_W(5)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .ctrl_reg_in  (ctrl_reg_in),
    .ctrl_reg_out (ctrl_reg_out),
    .ctrl_reg_we  (ctrl_reg_we),
    .dp_load      (dp_load),
    .dp_iter_en   (dp_iter_en),
    .dp_iter_idx  (dp_iter_idx),
    .dp_mode      (dp_mode),
    .dp_overflow  (dp_overflow),
    .result_latch (result_latch),
    .irq          (irq)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Field rules for each kind of write-back.
  function automatic logic [31:0] load_fn(input logic [31:0] v);
    return (v & ~32'hB000_0009) | 32'h4000_0000;
  endfunction
  function automatic logic [31:0] err_fn(input logic [31:0] v);
    return (v & ~32'h4000_0009) | 32'h9000_0000;
  endfunction
  function automatic logic [31:0] ack_fn(input logic [31:0] v);
    return v & ~32'hB000_0008;
  endfunction
  function automatic logic [31:0] done_fn(input logic [31:0] v, input logic ovf);
    return (v & ~32'h6000_0001) | 32'h8000_0000 | (ovf ? 32'h2000_0000 : 32'h0);
  endfunction

  function automatic logic [8:0] strb(input logic ld, input logic it, input logic [4:0] ix,
                                      input logic rl, input logic we);
    return {ld, it, ix, rl, we};
  endfunction

  // One cycle: check outputs at the negedge, then update the modelled control register.
  task automatic tick(input logic [8:0] exp_strb, input logic [31:0] exp_out);
    logic [8:0] obs;
    @(negedge clk);
    obs = {dp_load, dp_iter_en, (dp_iter_en ? dp_iter_idx : 5'd0), result_latch, ctrl_reg_we};
    chk_val("strobes", 32'(obs), 32'(exp_strb));
    if (exp_strb[0]) chk_val("writeback", ctrl_reg_out, exp_out);
    chk_val("irq", 32'(irq), 32'(ctrl_reg_in[31] & ctrl_reg_in[2]));
    if (pend_we) ctrl_reg_in = pend_val;
    else if (sw_pend) ctrl_reg_in = {ctrl_reg_in[31:24], sw_val[23:0]};
    sw_pend  = 1'b0;
    pend_we  = ctrl_reg_we;
    pend_val = ctrl_reg_out;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick(9'd0, 32'h0);
      dp_overflow = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_val("reset_strobes",
            32'({ctrl_reg_we, dp_load, dp_iter_en, dp_iter_idx, dp_mode, result_latch, irq}), 32'h0);
    chk_val("reset_out", ctrl_reg_out, 32'h0);
    ctrl_reg_in = 32'h0;
    pend_we     = 1'b0;
    sw_pend     = 1'b0;
    dp_overflow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Software write followed by the predicted response timeline.
  task automatic op(input logic [31:0] sw, input logic [31:0] ovf_mask,
                    input int restart_idx, input int abort_idx);
    logic [31:0] v;
    logic [31:0] exp_done;
    logic        ovf_any;
    logic        mode;
    int          n;
    sw_val  = sw;
    sw_pend = 1'b1;
    tick(9'd0, 32'h0);
    dp_overflow = 1'($urandom_range(0, 1));
    v = ctrl_reg_in;
    n = int'(v[8:4]);
    if (v[0] && n >= 1 && n <= 16) begin
      mode    = v[1];
      ovf_any = 1'b0;
      tick(strb(1'b1, 1'b0, 5'd0, 1'b0, 1'b1), load_fn(v));
      chk_val("mode_load", 32'(dp_mode), 32'(mode));
      dp_overflow = 1'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) begin
        if (j == restart_idx) begin
          sw_val  = ctrl_reg_in | 32'h1;
          sw_pend = 1'b1;
        end
        tick(strb(1'b0, 1'b1, 5'(j), 1'b0, 1'b0), 32'h0);
        chk_val("mode_iter", 32'(dp_mode), 32'(mode));
        if (j == abort_idx) begin
          do_reset();
          idle_ticks(24);
          return;
        end
        dp_overflow = ovf_mask[j];
        ovf_any     = ovf_any | ovf_mask[j];
      end
      tick(strb(1'b0, 1'b0, 5'd0, 1'b1, 1'b0), 32'h0);
      chk_val("mode_capture", 32'(dp_mode), 32'(mode));
      dp_overflow = 1'($urandom_range(0, 1));
      exp_done = done_fn(ctrl_reg_in, ovf_any);
      tick(strb(1'b0, 1'b0, 5'd0, 1'b0, 1'b1), exp_done);
    end else if (v[0]) begin
      tick(strb(1'b0, 1'b0, 5'd0, 1'b0, 1'b1), err_fn(v));
    end else if (v[3]) begin
      tick(strb(1'b0, 1'b0, 5'd0, 1'b0, 1'b1), ack_fn(v));
    end
    idle_ticks(4);
  endtask

  initial begin
    logic [31:0] sw;
    logic [4:0]  cnt;
    int          kind;
    rst_n       = 1'b1;
    ctrl_reg_in = 32'h0;
    dp_overflow = 1'b0;
    pend_we     = 1'b0;
    pend_val    = 32'h0;
    sw_pend     = 1'b0;
    sw_val      = 32'h0;
    @(negedge clk);
    do_reset();
    idle_ticks(3);

    op(32'h0000_00C1, 32'h0, -1, -1);           // rotation, 12 iterations
    op(32'h0000_0005, 32'h0, -1, -1);           // count 0 with ie -> error + irq
    op(32'h9000_000C, 32'h0, -1, -1);           // ack clears done/err, irq drops
    op(32'h0000_0083, 32'h0000_0080, -1, -1);   // vectoring, overflow on last iteration
    op(32'h0000_0101, 32'h0, 4, -1);            // start re-written mid-run
    idle_ticks(36);
    op(32'h0000_00A1, 32'h0, -1, 6);            // reset at idx 6
    op(32'h0000_00C1, 32'h0000_0003, -1, -1);
    op(32'h0000_0011, 32'h0, -1, -1);           // count 1
    op(32'h0000_0107, 32'h0000_8000, -1, -1);   // count 16
    op(32'h0000_0111, 32'h0, -1, -1);           // count 17 -> error
    op(32'h0000_000C, 32'h0, -1, -1);
    op(32'h0000_01F9, 32'h0, -1, -1);           // count 31 with ack -> error, ack cleared
    op(32'h0000_0008, 32'h0, -1, -1);

    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      cnt = 5'($urandom_range(1, 16));
      else if (kind <= 7) cnt = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
      else                cnt = 5'($urandom_range(0, 31));
      sw = {8'h00, 15'($urandom), cnt, 4'($urandom)};
      if (kind <= 7)      sw[0] = 1'b1;
      else if (kind == 8) begin sw[0] = 1'b0; sw[3] = 1'b1; end
      else                begin sw[0] = 1'b0; sw[3] = 1'b0; end
      op(sw, $urandom & $urandom & $urandom, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
